// File: rtl/q_8_34b_pkg.sv
// rtl/q_8_34b_pkg.sv - shared types and sizing helpers for the q_8_34b ones counter
package q_8_34b_pkg;

  typedef enum logic [1:0] {S_IDLE, S_1, S_2, S_3} state_t;

  localparam int DP_WIDTH = 8;

  // Counter width able to hold every value 0..width.
  function automatic int cw_of(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/q_8_34b_datapath_if.sv
// rtl/q_8_34b_datapath_if.sv - controller/datapath strobes, status and result bundle
interface q_8_34b_datapath_if
  import q_8_34b_pkg::*;
#(
  parameter int WIDTH = DP_WIDTH
);
  localparam int CW = cw_of(WIDTH);

  logic             load_regs;
  logic             incr_r2;
  logic             shift;
  logic [WIDTH-1:0] data_in;
  logic             zero;
  logic             E;
  logic [CW-1:0]    count;
  logic [CW-1:0]    result;
  logic             result_valid;

  modport master (
    output load_regs, incr_r2, shift, data_in,
    input  zero, E, count, result, result_valid
  );

  modport slave (
    input  load_regs, incr_r2, shift, data_in,
    output zero, E, count, result, result_valid
  );

endinterface

// File: rtl/q_8_34b_datapath.sv
// rtl/q_8_34b_datapath.sv - R1/E/R2 registers and result capture for the ones counter
// Optional Q_8_34B_PROTOCOL_CHK_EN adds a sticky proto_err flag for illegal strobe combinations.
module q_8_34b_datapath
  import q_8_34b_pkg::*;
#(
  parameter int WIDTH = DP_WIDTH,
  parameter int CW    = cw_of(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_b,
`ifdef Q_8_34B_PROTOCOL_CHK_EN
  output logic                 proto_err,
`endif
  q_8_34b_datapath_if.slave    bus
);

  logic [WIDTH-1:0] r1;
  logic             e_q;
  logic [CW-1:0]    r2;
  logic [CW-1:0]    result_q;
  logic             result_valid_q;
  logic             zero_c;

  assign zero_c           = (r1 == '0);
  assign bus.zero         = zero_c;
  assign bus.E            = e_q;
  assign bus.count        = r2;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r1             <= '0;
      e_q            <= 1'b0;
      r2             <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else if (bus.load_regs) begin
      // All-ones start so the controller's first increment lands on zero.
      r1             <= bus.data_in;
      e_q            <= 1'b0;
      r2             <= '1;
      result_valid_q <= 1'b0;
    end else begin
      if (bus.shift) begin
        {e_q, r1} <= {r1, 1'b0};
      end
      if (bus.incr_r2) begin
        r2 <= r2 + CW'(1);
      end
      if (bus.incr_r2 && zero_c) begin
        result_q       <= r2 + CW'(1);
        result_valid_q <= 1'b1;
      end
    end
  end

`ifdef Q_8_34B_PROTOCOL_CHK_EN
  logic bad_combo;

  assign bad_combo = (bus.load_regs && (bus.shift || bus.incr_r2)) ||
                     (bus.shift && bus.incr_r2);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      proto_err <= 1'b0;
    end else if (bad_combo) begin
      proto_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_q_8_34b_datapath.sv
// tb/tb_q_8_34b_datapath.sv - directed self-checking bench for q_8_34b_datapath
module tb_q_8_34b_datapath;
  import q_8_34b_pkg::*;

  logic clk;
  logic rst_b;
`ifdef Q_8_34B_PROTOCOL_CHK_EN
  logic proto_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  q_8_34b_datapath_if #(.WIDTH(8)) bus ();

  q_8_34b_datapath #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
`ifdef Q_8_34B_PROTOCOL_CHK_EN
    .proto_err (proto_err),
`endif
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic l, input logic i, input logic s, input logic [7:0] d);
    bus.load_regs = l;
    bus.incr_r2   = i;
    bus.shift     = s;
    bus.data_in   = d;
    tick();
    bus.load_regs = 1'b0;
    bus.incr_r2   = 1'b0;
    bus.shift     = 1'b0;
  endtask

  // Controller model: incr (S_1), stop on zero, else shift until a one falls out.
  task automatic run_count(input logic [7:0] d, input int exp, input string tag);
    int   guard;
    logic done;
    logic z;
    pulse(1'b1, 1'b0, 1'b0, d);
    done  = 1'b0;
    guard = 0;
    while (!done && guard < 64) begin
      guard++;
      z = bus.zero;
      pulse(1'b0, 1'b1, 1'b0, 8'h00);
      if (z) begin
        done = 1'b1;
      end else begin
        do begin
          pulse(1'b0, 1'b0, 1'b1, 8'h00);
          guard++;
        end while (!bus.E && guard < 64);
      end
    end
    chk({tag, "_done"},   32'(done), 32'd1);
    chk({tag, "_result"}, 32'(bus.result), 32'(exp));
    chk({tag, "_valid"},  32'(bus.result_valid), 32'd1);
    chk({tag, "_count"},  32'(bus.count), 32'(exp));
  endtask

  initial begin
    rst_b         = 1'b0;
    bus.load_regs = 1'b0;
    bus.incr_r2   = 1'b0;
    bus.shift     = 1'b0;
    bus.data_in   = 8'h00;
    #12;
    chk("rst_zero",   32'(bus.zero), 32'd1);
    chk("rst_e",      32'(bus.E), 32'd0);
    chk("rst_count",  32'(bus.count), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_valid",  32'(bus.result_valid), 32'd0);
    rst_b = 1'b1;

    pulse(1'b1, 1'b0, 1'b0, 8'hB2);
    chk("load_r1",    32'(dut.r1), 32'hB2);
    chk("load_count", 32'(bus.count), 32'hF);
    chk("load_e",     32'(bus.E), 32'd0);
    chk("load_zero",  32'(bus.zero), 32'd0);
    chk("load_valid", 32'(bus.result_valid), 32'd0);

    run_count(8'hB2, 4, "cnt_b2");
    pulse(1'b0, 1'b0, 1'b1, 8'h00);
    chk("sticky_result", 32'(bus.result), 32'd4);
    chk("sticky_valid",  32'(bus.result_valid), 32'd1);
    pulse(1'b1, 1'b0, 1'b0, 8'h3C);
    chk("reload_valid",  32'(bus.result_valid), 32'd0);
    chk("reload_result", 32'(bus.result), 32'd4);

    run_count(8'hFF, 8, "cnt_ff");
    run_count(8'h00, 0, "cnt_00");
`ifdef Q_8_34B_PROTOCOL_CHK_EN
    chk("proto_clean", 32'(proto_err), 32'd0);
`endif

    pulse(1'b1, 1'b0, 1'b0, 8'h81);
    pulse(1'b0, 1'b0, 1'b1, 8'h00);
    chk("sh1_e", 32'(bus.E), 32'd1);
    pulse(1'b0, 1'b0, 1'b1, 8'h00);
    chk("sh2_e", 32'(bus.E), 32'd0);
    pulse(1'b0, 1'b0, 1'b1, 8'h00);
    chk("sh3_e",    32'(bus.E), 32'd0);
    chk("sh3_r1",   32'(dut.r1), 32'h08);
    chk("sh3_zero", 32'(bus.zero), 32'd0);

    pulse(1'b1, 1'b0, 1'b0, 8'h80);
    pulse(1'b0, 1'b0, 1'b1, 8'h00);
    chk("shz_e",    32'(bus.E), 32'd1);
    chk("shz_zero", 32'(bus.zero), 32'd1);
    pulse(1'b0, 1'b0, 1'b1, 8'h00);
    chk("shz2_e",   32'(bus.E), 32'd0);
    chk("shz2_r1",  32'(dut.r1), 32'h00);

    pulse(1'b0, 1'b0, 1'b1, 8'h00);
    pulse(1'b1, 1'b1, 1'b1, 8'h0F);
    chk("prio_r1",    32'(dut.r1), 32'h0F);
    chk("prio_count", 32'(bus.count), 32'hF);
    chk("prio_e",     32'(bus.E), 32'd0);
    chk("prio_valid", 32'(bus.result_valid), 32'd0);
`ifdef Q_8_34B_PROTOCOL_CHK_EN
    chk("proto_set", 32'(proto_err), 32'd1);
    tick();
    tick();
    chk("proto_hold", 32'(proto_err), 32'd1);
`endif

    run_count(8'hFF, 8, "cnt_pre_rst");
    pulse(1'b1, 1'b0, 1'b0, 8'hA5);
    pulse(1'b0, 1'b0, 1'b1, 8'h00);
    chk("pre_rst_e", 32'(bus.E), 32'd1);
    #2;
    rst_b = 1'b0;
    #1;
    chk("arst_r1",     32'(dut.r1), 32'h00);
    chk("arst_zero",   32'(bus.zero), 32'd1);
    chk("arst_e",      32'(bus.E), 32'd0);
    chk("arst_count",  32'(bus.count), 32'd0);
    chk("arst_result", 32'(bus.result), 32'd0);
    chk("arst_valid",  32'(bus.result_valid), 32'd0);
`ifdef Q_8_34B_PROTOCOL_CHK_EN
    chk("arst_proto",  32'(proto_err), 32'd0);
`endif
    #1;
    rst_b = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
